memarbiter: RTL

Two-port memory access controller for the MIPS core. It arbitrates between the instruction-fetch port and the load/store port and decodes each accepted address into the internal memory window (0x1000–0x13FF) or the external bus. It sequences a single-cycle internal SRAM access or a req/ack external transaction with timeout. It sits between the core's memory interface and both memories, and replaces the ad-hoc combinational chip-select path.

---
 rtl/memarbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/memarbiter.sv
// memarbiter: round-robin arbiter between the fetch and load/store ports. Each granted
// access goes either to the internal SRAM window or to a req/ack external bus with timeout.
module memarbiter #(
    parameter logic [31:0] INT_BASE    = 32'h1000,
    parameter logic [31:0] INT_SIZE    = 32'h400,
    parameter int unsigned EXT_TIMEOUT = 15,
    localparam int unsigned AW = $clog2(INT_SIZE),
    localparam int unsigned CW = $clog2(EXT_TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          int_en,
    output logic          int_we,
    output logic [AW-1:0] int_addr,
    output logic [31:0]   int_wdata,
    input  logic [31:0]   int_rdata,
    output logic          ext_req,
    output logic          ext_we,
    output logic [31:0]   ext_addr,
    output logic [31:0]   ext_wdata,
    input  logic [31:0]   ext_rdata,
    input  logic          ext_ack,
    output logic          bus_err
);

    typedef enum logic [1:0] {IDLE, INT, EXT, RESP} state_t;

    state_t        state;
    logic          own_d;
    logic          last_d;
    logic          mask_i;
    logic          mask_d;
    logic          is_int;
    logic          we;
    logic          err;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [CW-1:0] cnt;

    logic          elig_i;
    logic          elig_d;
    logic          pick_d;
    logic [31:0]   sel_addr;
    logic          sel_int;
    logic [AW-1:0] off;
    logic [31:0]   resp_data;

    // Both eligible: the port not granted last wins
    assign elig_i   = i_req & ~mask_i;
    assign elig_d   = d_req & ~mask_d;
    assign pick_d   = elig_d & (~elig_i | ~last_d);
    assign sel_addr = pick_d ? d_addr : i_addr;
    // Unsigned wrap makes addresses below INT_BASE fail the window test too
    assign sel_int  = (sel_addr - INT_BASE) < INT_SIZE;
    assign off      = addr[AW-1:0] - INT_BASE[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            own_d  <= 1'b0;
            last_d <= 1'b0;
            mask_i <= 1'b0;
            mask_d <= 1'b0;
            is_int <= 1'b0;
            we     <= 1'b0;
            err    <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask_i <= 1'b0;
                    mask_d <= 1'b0;
                    if (elig_i | elig_d) begin
                        own_d  <= pick_d;
                        last_d <= pick_d;
                        addr   <= sel_addr;
                        we     <= pick_d & d_we;
                        wdata  <= pick_d ? d_wdata : '0;
                        is_int <= sel_int;
                        err    <= 1'b0;
                        rdata  <= '0;
                        cnt    <= '0;
                        state  <= sel_int ? INT : EXT;
                    end
                end
                INT: state <= RESP;
                EXT: begin
                    if (ext_ack) begin
                        rdata <= we ? '0 : ext_rdata;
                        state <= RESP;
                    end else if (cnt == CW'(EXT_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    mask_i <= ~own_d;
                    mask_d <= own_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM read data arrives in RESP, one cycle after int_en, and is forwarded directly
    assign resp_data = (is_int && !we) ? int_rdata : rdata;

    assign int_en    = (state == INT);
    assign int_we    = int_en & we;
    assign int_addr  = int_en ? off : '0;
    assign int_wdata = int_en ? wdata : '0;

    assign ext_req   = (state == EXT);
    assign ext_we    = ext_req & we;
    assign ext_addr  = ext_req ? addr : '0;
    assign ext_wdata = ext_req ? wdata : '0;

    assign i_ready   = (state == RESP) & ~own_d;
    assign d_ready   = (state == RESP) & own_d;
    assign i_rdata   = i_ready ? resp_data : '0;
    assign d_rdata   = d_ready ? resp_data : '0;
    assign bus_err   = (state == RESP) & err;

endmodule
